adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one instance of the existing 32-bit `adder` (ports input1, input2, out) among NREQ requesters, e.g. the branch-target and AGU paths in sail-core.
- Round-robin grant, one transaction in flight.
- Operands are registered into the adder; the result is registered and returned on a per-requester valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters (2..8).
- PTR_W, $clog2(NREQ) (minimum 1), localparam giving the width of the grant pointer and rsp_id.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  NREQ  requester k has an operand pair pending.
- req_a  in  32*NREQ  operand A; slice [32k+31:32k] belongs to requester k.
- req_b  in  32*NREQ  operand B, sliced the same way.
- req_ready  out  NREQ  one-hot (or zero) accept strobe.
- rsp_valid  out  NREQ  one-hot (or zero) result-valid to the owning requester.
- rsp_ready  in  NREQ  requester k can take its result.
- rsp_data  out  32  sum, (A+B) mod 2^32.
- rsp_id  out  PTR_W  index of the current owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, op_a=op_b=0, rsp_data=0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, busy=0.
- Reset asserted mid-transaction aborts it: no rsp_valid is produced and the request is not retried.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - winner = first k with req_valid[k], searching k = rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[winner]=1 combinationally, only while in IDLE; all other req_ready bits are 0.
  - On that accept edge, latch op_a/op_b from the winner's slices, set owner=winner, and go to EXEC.
  - No req_valid set: stay in IDLE.
- EXEC:
  - The adder sees op_a/op_b.
  - On the next edge, rsp_data <= adder.out, then go to RESP.
  - req_valid changes in this state are ignored.
- RESP:
  - rsp_valid[owner]=1 and rsp_id=owner.
  - rsp_data and rsp_valid stay stable until rsp_ready[owner]=1.
  - rsp_ready bits of non-owners are ignored.
  - On the handshake edge: rr_ptr <= (owner+1) mod NREQ, go to IDLE.
- Latency and throughput:
  - Accept at edge T gives rsp_valid high during the cycle after edge T+1.
  - Minimum 3 cycles per transaction; no accept in the same cycle as a response handshake.
- Arithmetic: unsigned 32-bit add, carry discarded (0xFFFFFFFF+1 = 0). No overflow flag.
- Fairness: a continuously requesting k is served within NREQ transactions.
- Invariants:
  - req_ready and rsp_valid are never both nonzero.
  - Each is at most one-hot.
  - The pointer wraps NREQ-1 → 0.
- Requester rules:
  - A requester must hold req_valid and its operands until req_ready.
  - Dropping req_valid before acceptance is allowed; the arbiter simply re-picks.

Decomposition:
- Package adder_arb_pkg:
  - DATA_W=32.
  - State encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
- Sub-modules:
  - rr_pick: combinational round-robin picker. Inputs req[NREQ-1:0] and ptr; outputs gnt one-hot, idx, any.
  - Instantiate the existing `adder` unchanged; do not reimplement it.

Test Plan:
- Single request: NREQ=2, req_valid=01, a=5, b=7, rsp_ready=01 held → req_ready=01 for one cycle, rsp_valid=01 two edges later, rsp_data=12, rsp_id=0; busy 1→0.
- Wrap-around: a=0xFFFFFFFF, b=1 → rsp_data=0. Also a=0x80000000, b=0x80000000 → 0.
- Round-robin: both requesters valid continuously with distinct operands → grant order 0,1,0,1 over 4 transactions; each result matches its own requester's A+B.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_data stable, req_ready stays 0 for the other requester; releasing rsp_ready → IDLE, next grant goes to the other requester.
- Reset mid-op: assert reset asynchronously during EXEC → outputs immediately 0, state IDLE, rr_ptr=0, no response. After release, a pending request from requester 1 alone is accepted normally.
- Random soak: NREQ=4, 1000 random valid/ready patterns → scoreboard matches every sum to its requester, no starvation beyond 4 transactions, one-hot invariants hold.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants for the adder-sharing arbiter: datapath width and FSM state codes.
package adder_arb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/adder.sv
// Existing 32-bit combinational adder from sail-core; carry out is dropped.
module adder (
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] out
);

  assign out = input1 + input2;

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one adder among NREQ requesters; accept -> registered sum in RESP two edges later.
// One transaction in flight; the result is held until the owner asserts rsp_ready, no new accepts meanwhile.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [PTR_W-1:0]       rsp_id,
  output logic                   busy
);

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;

  logic [NREQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [PTR_W-1:0]  next_ptr;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  adder u_adder (
    .input1 (op_a),
    .input2 (op_b),
    .out    (sum)
  );

  // Explicit wrap so non-power-of-two NREQ never leaves the pointer out of range.
  assign next_ptr = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            op_a  <= req_a[pick_idx*DATA_W +: DATA_W];
            op_b  <= req_b[pick_idx*DATA_W +: DATA_W];
            owner <= pick_idx;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= sum;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE && !reset) ? pick_gnt : '0;
  assign rsp_valid = (state == ST_RESP) ? (NREQ'(1) << owner) : '0;
  assign rsp_id    = owner;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: transaction-level model checked every cycle plus directed scenarios and a random soak.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int PW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [31:0]       rsp_data;
  logic [PW-1:0]     rsp_id;
  logic              busy;

  int tests = 0;
  int fails = 0;

  adder_share_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Round-robin choice stated plainly: first valid index scanning from ptr upward, modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  // Model: phase 0 = free, 1 = sum being computed, 2 = result offered to owner.
  int          m_phase, m_ptr, m_owner, m_w;
  logic [31:0] m_sum, m_data;
  int          waits[NREQ];
  logic [NREQ-1:0] e_rr, e_rv;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_data = '0;
      for (int k = 0; k < NREQ; k++) waits[k] = 0;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data",  rsp_data,       32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
    end else begin
      e_rr = '0; e_rv = '0; m_w = -1;
      if (m_phase == 0) begin
        m_w = pick(req_valid, m_ptr);
        if (m_w >= 0) e_rr = NREQ'(1) << m_w;
      end
      if (m_phase == 2) e_rv = NREQ'(1) << m_owner;
      chk("mdl_req_ready", 32'(req_ready), 32'(e_rr));
      chk("mdl_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("mdl_rsp_data",  rsp_data,       m_data);
      chk("mdl_busy",      32'(busy),      32'(m_phase != 0));
      if (m_phase == 2) chk("mdl_rsp_id", 32'(rsp_id), 32'(m_owner));
      chk("mdl_invariants",
          {29'd0, $onehot0(req_ready), $onehot0(rsp_valid), !(|req_ready && |rsp_valid)}, 32'h7);
      case (m_phase)
        0: if (m_w >= 0) begin
             for (int k = 0; k < NREQ; k++) begin
               if (k == m_w || !req_valid[k]) waits[k] = 0;
               else begin
                 waits[k]++;
                 chk("mdl_starvation", 32'(waits[k] <= NREQ - 1), 32'h1);
               end
             end
             m_owner = m_w;
             m_sum   = req_a[32*m_w +: 32] + req_b[32*m_w +: 32];
             m_phase = 1;
           end
        1: begin m_data = m_sum; m_phase = 2; end
        default: if (rsp_ready[m_owner]) begin
             m_ptr   = (m_owner + 1) % NREQ;
             m_phase = 0;
           end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
  endtask

  task automatic wait_ready(input string name, input logic [NREQ-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    chk(name, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(input string name, input logic [NREQ-1:0] ev, input logic [31:0] ed,
                          input logic [PW-1:0] eid);
    int n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 20) begin @(negedge clk); n++; end
    chk({name, "_valid"}, 32'(rsp_valid), 32'(ev));
    chk({name, "_data"},  rsp_data,       ed);
    chk({name, "_id"},    32'(rsp_id),    32'(eid));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk({name, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic txn(input string name, input int k, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    step();
    set_ops(k, a, b);
    req_valid[k] = 1'b1;
    wait_ready({name, "_rdy"}, NREQ'(1) << k);
    step();
    req_valid[k] = 1'b0;
    wait_rsp(name, NREQ'(1) << k, exp, PW'(k));
    wait_idle(name);
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  logic [31:0]     rr_exp [4] = '{32'd1000, 32'd2001, 32'd1008, 32'd2009};
  int              cnt[2];
  logic [NREQ-1:0] snap, pending;

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;

    chk("pin_pick_wrap", 32'(pick(4'b1001, 1)), 32'd3);
    chk("pin_pick_at_ptr", 32'(pick(4'b0110, 2)), 32'd2);
    chk("pin_pick_none", 32'(pick(4'b0000, 0)), 32'hFFFFFFFF);

    step(); step();
    reset = 1'b0;

    // Single request from requester 0: 5 + 7.
    step();
    rsp_ready = 4'b0001;
    set_ops(0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'h1);
    chk("single_busy_before", 32'(busy), 32'h0);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_busy_exec", 32'(busy), 32'h1);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'd12);
    chk("single_rsp_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    chk("single_busy_after", 32'(busy), 32'h0);

    rsp_ready = '1;
    txn("wrap_ones", 0, 32'hFFFFFFFF, 32'h1, 32'h0);
    txn("wrap_msb", 0, 32'h80000000, 32'h80000000, 32'h0);
    txn("top_req", 3, 32'd10, 32'd20, 32'd30);

    // Round robin between two continuously requesting ports.
    pulse_reset();
    cnt[0] = 0; cnt[1] = 0;
    set_ops(0, 32'd1000, 32'd0);
    set_ops(1, 32'd2000, 32'd1);
    req_valid = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      wait_ready("rr_grant", NREQ'(1) << (t % 2));
      step();
      cnt[t % 2]++;
      set_ops(t % 2, 32'(1000 * (t % 2 + 1) + cnt[t % 2]), 32'(7 * cnt[t % 2] + t % 2));
      wait_rsp("rr_rsp", NREQ'(1) << (t % 2), rr_exp[t], PW'(t % 2));
    end
    step();
    req_valid = '0;
    wait_idle("rr");

    // Backpressure: only a non-owner signals ready for five cycles.
    step();
    rsp_ready = 4'b0010;
    set_ops(0, 32'd11, 32'd22);
    set_ops(1, 32'd33, 32'd44);
    req_valid = 4'b0011;
    wait_ready("bp_grant", 4'b0001);
    step();
    req_valid = 4'b0010;
    wait_rsp("bp_rsp", 4'b0001, 32'd33, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", rsp_data, 32'd33);
      chk("bp_no_ready", 32'(req_ready), 32'h0);
    end
    step();
    rsp_ready = '1;
    wait_ready("bp_next_grant", 4'b0010);
    step();
    req_valid = '0;
    wait_rsp("bp_next_rsp", 4'b0010, 32'd77, 2'd1);
    wait_idle("bp");

    // Asynchronous reset in the middle of EXEC.
    step();
    set_ops(0, 32'd100, 32'd200);
    req_valid = 4'b0001;
    wait_ready("rst_grant", 4'b0001);
    step();
    #2;
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_async_req_ready", 32'(req_ready), 32'h0);
    chk("rst_async_rsp_data", rsp_data, 32'h0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    // Pointer back at 0 means requester 1 wins over 3.
    step();
    set_ops(1, 32'h1234, 32'h1);
    set_ops(3, 32'h5, 32'h5);
    req_valid = 4'b1010;
    wait_ready("rst_after_grant", 4'b0010);
    step();
    req_valid = '0;
    wait_rsp("rst_after_rsp", 4'b0010, 32'h1235, 2'd1);
    wait_idle("rst_after");

    // Random soak: requesters hold until accepted, random response readiness.
    pending = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      snap = req_ready;
      step();
      for (int k = 0; k < NREQ; k++) begin
        if (snap[k]) begin
          pending[k]   = 1'b0;
          req_valid[k] = 1'b0;
        end
        if (!pending[k] && $urandom_range(0, 2) == 0) begin
          set_ops(k, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom);
          pending[k]   = 1'b1;
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = NREQ'($urandom);
    end
    step();
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) @(negedge clk);
    wait_idle("soak_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
